// File: rtl/harvard_data_bridge_if.sv
// Port bundles for harvard_data_bridge.
// cpu_data_if: CPU Harvard data port (master = CPU, slave = bridge).
// dbus_if: waitrequest/readdatavalid data bus (master = bridge, slave = memory).
interface cpu_data_if;
   logic [31:0] cpu_data_address;
   logic        cpu_data_read;
   logic        cpu_data_write;
   logic [31:0] cpu_data_writedata;
   logic [31:0] cpu_data_readdata;
   logic        cpu_stall;

   modport master (
      output cpu_data_address, cpu_data_read, cpu_data_write, cpu_data_writedata,
      input  cpu_data_readdata, cpu_stall
   );
   modport slave (
      input  cpu_data_address, cpu_data_read, cpu_data_write, cpu_data_writedata,
      output cpu_data_readdata, cpu_stall
   );
endinterface

interface dbus_if;
   logic [31:0] bus_address;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_writedata;
   logic [3:0]  bus_byteenable;
   logic        bus_waitrequest;
   logic        bus_readdatavalid;
   logic [31:0] bus_readdata;

   modport master (
      output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
      input  bus_waitrequest, bus_readdatavalid, bus_readdata
   );
   modport slave (
      input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
      output bus_waitrequest, bus_readdatavalid, bus_readdata
   );
endinterface

// File: rtl/harvard_data_bridge.sv
// harvard_data_bridge: turns the CPU's combinational-read / single-cycle-write
// data port into a waitrequest/readdatavalid bus access, one at a time.
// cpu_stall freezes the CPU until the access completes; a watchdog aborts
// hung accesses and sets a sticky bus_error.
// Optional macro DBRIDGE_READ_HIT_EN: one-entry read buffer that serves a
// repeated read in IDLE without a bus access.
module harvard_data_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_READDATA   = 32'h0000_0000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   cpu_data_if.slave  cpu,
   dbus_if.master     bus,
   output logic       o_bus_error
);

   localparam int          CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_DONE, S_RD_REQ, S_RD_WAIT, S_RD_DONE
   } state_t;

   state_t          r_state;
   logic            r_rd;
   logic            r_wr;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rdata;
   logic            r_err;
   logic [CW-1:0]   r_cnt;

   logic            w_hit;
   logic            w_busy;
   logic            w_tmo;
   logic            w_abort;
   logic            w_stall;
   logic [CW-1:0]   w_cnt_nxt;

`ifdef DBRIDGE_READ_HIT_EN
   logic [31:0]     r_buf_addr;
   logic [31:0]     r_buf_data;
   logic            r_buf_vld;
   logic            w_hit_rd;

   assign w_hit    = r_buf_vld && (r_buf_addr == cpu.cpu_data_address);
   assign w_hit_rd = (r_state == S_IDLE) && cpu.cpu_data_read && !cpu.cpu_data_write && w_hit;
   assign cpu.cpu_data_readdata = w_hit_rd ? r_buf_data : r_rdata;
`else
   assign w_hit = 1'b0;
   assign cpu.cpu_data_readdata = r_rdata;
`endif

   assign w_busy    = (r_state == S_WR_REQ) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
   assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(LAST));
   assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // watchdog fires only when the bus is not completing the access this cycle
   always_comb begin
      w_abort = 1'b0;
      case (r_state)
         S_WR_REQ, S_RD_REQ: w_abort = w_tmo && bus.bus_waitrequest;
         S_RD_WAIT:          w_abort = w_tmo && !bus.bus_readdatavalid;
         default:            w_abort = 1'b0;
      endcase
   end

   // stall: combinational on a new miss in IDLE, held while the bus is owed
   // something; forced low in reset so the CPU's gated reset can act
   always_comb begin
      w_stall = 1'b0;
      if (!i_reset) begin
         case (r_state)
            S_IDLE:                       w_stall = cpu.cpu_data_write ||
                                                    (cpu.cpu_data_read && !w_hit);
            S_WR_REQ, S_RD_REQ, S_RD_WAIT: w_stall = 1'b1;
            default:                      w_stall = 1'b0;
         endcase
      end
   end

   assign cpu.cpu_stall      = w_stall;
   assign bus.bus_address    = r_addr;
   assign bus.bus_read       = r_rd;
   assign bus.bus_write      = r_wr;
   assign bus.bus_writedata  = r_wdata;
   assign bus.bus_byteenable = 4'hF;
   assign o_bus_error        = r_err;

   // main FSM with registered strobes, capture data and watchdog counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_cnt <= w_busy ? w_cnt_nxt : '0;
         case (r_state)
            S_IDLE: begin
               if (cpu.cpu_data_write) begin
                  r_addr  <= cpu.cpu_data_address;
                  r_wdata <= cpu.cpu_data_writedata;
                  r_wr    <= 1'b1;
                  r_state <= S_WR_REQ;
               end else if (cpu.cpu_data_read && !w_hit) begin
                  r_addr  <= cpu.cpu_data_address;
                  r_rd    <= 1'b1;
                  r_state <= S_RD_REQ;
               end
            end
            S_WR_REQ: begin
               if (!bus.bus_waitrequest || w_abort) begin
                  r_wr    <= 1'b0;
                  r_state <= S_WR_DONE;
               end
               if (w_abort) r_err <= 1'b1;
            end
            S_RD_REQ: begin
               if (!bus.bus_waitrequest) begin
                  r_rd    <= 1'b0;
                  r_state <= S_RD_WAIT;
               end else if (w_abort) begin
                  r_rd    <= 1'b0;
                  r_rdata <= ERR_READDATA;
                  r_err   <= 1'b1;
                  r_state <= S_RD_DONE;
               end
            end
            S_RD_WAIT: begin
               if (bus.bus_readdatavalid) begin
                  r_rdata <= bus.bus_readdata;
                  r_state <= S_RD_DONE;
               end else if (w_abort) begin
                  r_rdata <= ERR_READDATA;
                  r_err   <= 1'b1;
                  r_state <= S_RD_DONE;
               end
            end
            S_WR_DONE, S_RD_DONE: r_state <= S_IDLE;
            default:              r_state <= S_IDLE;
         endcase
      end
   end

`ifdef DBRIDGE_READ_HIT_EN
   // read buffer: filled with the captured word (valid by the RD_DONE release
   // cycle), follows accepted writes to its address, dropped on any abort
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_buf_vld  <= 1'b0;
         r_buf_addr <= '0;
         r_buf_data <= '0;
      end else if (w_abort) begin
         r_buf_vld  <= 1'b0;
      end else if (r_state == S_RD_WAIT && bus.bus_readdatavalid) begin
         r_buf_vld  <= 1'b1;
         r_buf_addr <= r_addr;
         r_buf_data <= bus.bus_readdata;
      end else if (r_state == S_WR_REQ && !bus.bus_waitrequest && r_addr == r_buf_addr) begin
         r_buf_data <= r_wdata;
      end
   end
`endif

endmodule

// File: tb/tb_harvard_data_bridge.sv
// Testbench for harvard_data_bridge: CPU driver, randomized bus slave,
// read scoreboard and write scoreboard against a memory-level reference.
module tb_harvard_data_bridge;
   localparam int unsigned TMO  = 8;
   localparam logic [31:0] ERRW = 32'hBAD0_BAD0;
`ifdef DBRIDGE_READ_HIT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bus_error;

   cpu_data_if cpu_i();
   dbus_if     bus_i();

   harvard_data_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_READDATA(ERRW)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .cpu         (cpu_i.slave),
      .bus         (bus_i.master),
      .o_bus_error (bus_error)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // reference memory (CPU view) and slave memory (bus view)
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] sim_mem [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
   endfunction
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction
   function automatic logic [31:0] sim_rd(input logic [31:0] a);
      return sim_mem.exists(a) ? sim_mem[a] : init_word(a);
   endfunction

   logic [31:0] exp_rd_q [$];
   logic [63:0] exp_wr_q [$];

   // slave behaviour knobs set by the driver per transaction
   int nxt_w = 0;
   int nxt_d = 0;
   bit stuck = 1'b0;
   int strobe_cyc = 0;
   int n_rd_acc = 0;
   int n_wr_acc = 0;

   // model state
   bit          mdl_err  = 1'b0;
   bit          mdl_vld  = 1'b0;
   logic [31:0] mdl_addr = '0;

   // bus slave: waitrequest/readdatavalid driven mid-cycle, write scoreboard
   initial begin
      int          wcnt;
      bit          active;
      int          rd_delay;
      logic [31:0] rd_data;
      logic [63:0] e;
      wcnt = 0; active = 1'b0; rd_delay = -1; rd_data = '0;
      bus_i.bus_waitrequest = 1'b0;
      bus_i.bus_readdatavalid = 1'b0;
      bus_i.bus_readdata = '0;
      forever begin
         @(negedge clk);
         bus_i.bus_readdatavalid = 1'b0;
         if (rd_delay == 0) begin
            bus_i.bus_readdatavalid = 1'b1;
            bus_i.bus_readdata = rd_data;
            rd_delay = -1;
         end else if (rd_delay > 0) begin
            rd_delay--;
         end
         if (reset) begin
            active = 1'b0;
            bus_i.bus_waitrequest = 1'b1;
         end else begin
            check("no_rd_wr_overlap", {31'b0, bus_i.bus_read & bus_i.bus_write}, 32'd0);
            if (bus_i.bus_read || bus_i.bus_write) begin
               strobe_cyc++;
               if (!active) begin
                  active = 1'b1;
                  wcnt = nxt_w;
               end
               if (stuck || wcnt > 0) begin
                  bus_i.bus_waitrequest = 1'b1;
                  if (wcnt > 0) wcnt--;
               end else begin
                  bus_i.bus_waitrequest = 1'b0;
                  active = 1'b0;
                  if (bus_i.bus_read) begin
                     n_rd_acc++;
                     rd_data = sim_rd(bus_i.bus_address);
                     rd_delay = nxt_d;
                  end else begin
                     n_wr_acc++;
                     check("wr_byteenable", {28'b0, bus_i.bus_byteenable}, 32'hF);
                     if (exp_wr_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL wr_unexpected: got write %h to %h, expected none",
                                 bus_i.bus_writedata, bus_i.bus_address);
                     end else begin
                        e = exp_wr_q.pop_front();
                        check("wr_addr", bus_i.bus_address, e[63:32]);
                        check("wr_data", bus_i.bus_writedata, e[31:0]);
                     end
                     sim_mem[bus_i.bus_address] = bus_i.bus_writedata;
                  end
               end
            end else begin
               bus_i.bus_waitrequest = 1'b0;
               active = 1'b0;
            end
         end
      end
   end

   // read scoreboard: a read commits on a cycle where the CPU is not stalled
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && cpu_i.cpu_data_read && !cpu_i.cpu_data_write && !cpu_i.cpu_stall) begin
            if (exp_rd_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rd_unexpected: got commit data %h, expected no read pending",
                        cpu_i.cpu_data_readdata);
            end else begin
               check("rd_data", cpu_i.cpu_data_readdata, exp_rd_q.pop_front());
            end
         end
      end
   end

   // issue one CPU access; expected latency comes from the access rules:
   // write 2+w stalls, read 3+w+d stalls, timeout 1+TMO stalls, hit 0
   task automatic do_txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                         input int w, input int dl, input bit stk, input string tag);
      int stalls, exp_st, exp_strb, rd0, wr0;
      bit hit, done;
      nxt_w = w; nxt_d = dl; stuck = stk; strobe_cyc = 0;
      rd0 = n_rd_acc; wr0 = n_wr_acc;
      hit = !is_wr && HIT_EN && mdl_vld && (mdl_addr == a);
      if (is_wr) begin
         if (!stk) begin
            exp_wr_q.push_back({a, d});
            ref_mem[a] = d;
         end
         exp_st = stk ? int'(TMO) + 1 : 2 + w;
      end else begin
         exp_rd_q.push_back(stk ? ERRW : ref_rd(a));
         exp_st = hit ? 0 : stk ? int'(TMO) + 1 : 3 + w + dl;
      end
      exp_strb = hit ? 0 : stk ? int'(TMO) : w + 1;
      if (stk) begin
         mdl_err = 1'b1;
         mdl_vld = 1'b0;
      end else if (!is_wr && !hit) begin
         mdl_vld = 1'b1;
         mdl_addr = a;
      end
      cpu_i.cpu_data_address   = a;
      cpu_i.cpu_data_read      = !is_wr;
      cpu_i.cpu_data_write     = is_wr;
      cpu_i.cpu_data_writedata = d;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (cpu_i.cpu_stall) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL %s_complete: stall still high after 64 cycles, expected release", tag);
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $fatal(1);
      end
      @(posedge clk); #1;
      cpu_i.cpu_data_read  = 1'b0;
      cpu_i.cpu_data_write = 1'b0;
      check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_st));
      check({tag, "_strobe_cycles"}, 32'(strobe_cyc), 32'(exp_strb));
      if (is_wr) check({tag, "_wr_accepts"}, 32'(n_wr_acc - wr0), stk ? 32'd0 : 32'd1);
      else       check({tag, "_rd_accepts"}, 32'(n_rd_acc - rd0), (stk || hit) ? 32'd0 : 32'd1);
      check({tag, "_bus_error"}, {31'b0, bus_error}, {31'b0, mdl_err});
   endtask

   initial begin
      bit          wr;
      logic [31:0] a;
      #200000;
      $display("FAIL global_time_limit: simulation still running, expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

   initial begin
      bit          wr;
      logic [31:0] a;
      // reset with a read held: stall must stay low
      cpu_i.cpu_data_address = 32'h1000;
      cpu_i.cpu_data_read = 1'b1;
      cpu_i.cpu_data_write = 1'b0;
      cpu_i.cpu_data_writedata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'b0, cpu_i.cpu_stall}, 32'd0);
      check("rst_bus_read", {31'b0, bus_i.bus_read}, 32'd0);
      check("rst_bus_write", {31'b0, bus_i.bus_write}, 32'd0);
      check("rst_bus_address", bus_i.bus_address, 32'd0);
      check("rst_bus_writedata", bus_i.bus_writedata, 32'd0);
      check("rst_readdata", cpu_i.cpu_data_readdata, 32'd0);
      check("rst_bus_error", {31'b0, bus_error}, 32'd0);
      check("rst_byteenable", {28'b0, bus_i.bus_byteenable}, 32'hF);
      @(posedge clk); #1;
      reset = 1'b0;
      cpu_i.cpu_data_read = 1'b0;
      @(posedge clk); #1;

      // directed cases
      sim_mem[32'h1004] = 32'h1234_5678;
      ref_mem[32'h1004] = 32'h1234_5678;
      do_txn(1'b1, 32'h1000, 32'hDEAD_BEEF, 0, 0, 1'b0, "wr0wait");
      do_txn(1'b0, 32'h1004, 32'h0, 2, 0, 1'b0, "rd2wait");
      do_txn(1'b0, 32'h1000, 32'h0, 0, 1, 1'b0, "b2b_rd");
      do_txn(1'b1, 32'h1008, 32'h0BAD_F00D, 1, 0, 1'b0, "b2b_wr");
      do_txn(1'b0, 32'h2000, 32'h0, 0, 0, 1'b0, "rd2000a");
      do_txn(1'b0, 32'h2000, 32'h0, 0, 0, 1'b0, "rd2000b");
      do_txn(1'b1, 32'h2000, 32'hA5A5_A5A5, 0, 0, 1'b0, "wr2000");
      do_txn(1'b0, 32'h2000, 32'h0, 1, 1, 1'b0, "rd2000c");

      // randomized mix over a small address window, back-to-back or gapped
      for (int i = 0; i < 40; i++) begin
         wr = ($urandom_range(0, 2) == 0);
         a  = 32'h3000 + 32'($urandom_range(0, 5)) * 32'd4;
         do_txn(wr, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, "rand");
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      // watchdog: hung read, then a normal access with error still sticky
      do_txn(1'b0, 32'h3004, 32'h0, 0, 0, 1'b1, "tmo_rd");
      do_txn(1'b0, 32'h3008, 32'h0, 1, 0, 1'b0, "after_tmo");
      do_txn(1'b1, 32'h300C, 32'h7777_7777, 0, 0, 1'b1, "tmo_wr");
      do_txn(1'b0, 32'h300C, 32'h0, 0, 0, 1'b0, "rd_after_tmo_wr");

      // reset while the read waits for data; late readdatavalid is ignored
      nxt_w = 0; nxt_d = 3; stuck = 1'b0;
      cpu_i.cpu_data_address = 32'h4000;
      cpu_i.cpu_data_read = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      cpu_i.cpu_data_read = 1'b0;
      @(negedge clk);
      check("rwait_rst_stall", {31'b0, cpu_i.cpu_stall}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      mdl_err = 1'b0;
      mdl_vld = 1'b0;
      @(negedge clk);
      check("rwait_post_bus_read", {31'b0, bus_i.bus_read}, 32'd0);
      check("rwait_post_stall", {31'b0, cpu_i.cpu_stall}, 32'd0);
      check("rwait_post_bus_error", {31'b0, bus_error}, 32'd0);
      repeat (5) @(negedge clk);
      check("rwait_late_rdv", cpu_i.cpu_data_readdata, 32'd0);
      @(posedge clk); #1;

      // recovery after reset
      do_txn(1'b0, 32'h4000, 32'h0, 1, 2, 1'b0, "post_rst_rd");
      do_txn(1'b1, 32'h4000, 32'h1357_9BDF, 0, 0, 1'b0, "post_rst_wr");
      do_txn(1'b0, 32'h4000, 32'h0, 0, 0, 1'b0, "post_rst_rd2");

      check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
      check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/harvard_data_bridge.md
Name: harvard_data_bridge

Overview:
- Sits between the CPU's Harvard data port and the data memory/interconnect.
- Converts the CPU's combinational-read, single-cycle-write port into a waitrequest/readdatavalid bus with at most one outstanding transaction.
- Drives `cpu_stall`; the top level ties CPU `clk_enable = !cpu_stall`, so the CPU freezes until each access completes.
- Includes a bus-timeout watchdog that reports hung transactions.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a request may wait in REQ or WAIT before abort; 0 disables the watchdog.
- ERR_READDATA, 32'h0000_0000: word returned to the CPU on a timed-out read.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high.
- cpu_data_address  input  32  word address from CPU; bits [1:0] are always 0.
- cpu_data_read  input  1  CPU read request.
- cpu_data_write  input  1  CPU write request.
- cpu_data_writedata  input  32  CPU store word.
- cpu_data_readdata  output  32  word returned to CPU.
- cpu_stall  output  1  high = CPU must not advance.
- bus_address  output  32  bus word address.
- bus_read  output  1  bus read strobe.
- bus_write  output  1  bus write strobe.
- bus_writedata  output  32  bus write word.
- bus_byteenable  output  4  constant 4'hF; the CPU merges partial stores itself.
- bus_waitrequest  input  1  bus not accepting the current strobe.
- bus_readdatavalid  input  1  read data valid, at least 1 cycle after acceptance.
- bus_readdata  input  32  bus read word.
- bus_error  output  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Clock/reset: one clock `clk`; synchronous active-high `reset`.
- Reset values: state=IDLE, bus_read=0, bus_write=0, bus_address=0, bus_writedata=0, cpu_data_readdata=0, bus_error=0, timeout counter=0, read buffer invalid.
- Stall during reset: `cpu_stall` is forced 0 while reset is high, so the CPU's own clk_enable-gated reset can take effect.
- State machine:
  - IDLE, cpu_data_write=1: latch address and writedata, go to WR_REQ. `cpu_stall` = 1 combinationally in that same cycle.
  - IDLE, cpu_data_read=1 and not a buffer hit: latch address, go to RD_REQ. `cpu_stall` = 1 combinationally.
  - IDLE, otherwise: `cpu_stall` = 0.
  - WR_REQ: bus_write=1 with latched address/data. When bus_waitrequest=0, go to WR_DONE.
  - WR_DONE: one cycle, `cpu_stall`=0, CPU requests ignored (the CPU commits this edge), then IDLE.
  - RD_REQ: bus_read=1. When bus_waitrequest=0, deassert and go to RD_WAIT.
  - RD_WAIT: when bus_readdatavalid=1, capture bus_readdata into `cpu_data_readdata` and go to RD_DONE. bus_readdatavalid in any other state is ignored.
  - RD_DONE: one cycle, `cpu_stall`=0, `cpu_data_readdata` holds the captured word, requests ignored, then IDLE.
- Stall timing: `cpu_stall` is 1 in WR_REQ, RD_REQ and RD_WAIT.
- Minimum latency:
  - Write: 2 stalled cycles plus 1 release cycle.
  - Read: 3 stalled cycles (IDLE detect, RD_REQ, RD_WAIT with readdatavalid) plus 1 release cycle.
- Simultaneous read and write in IDLE: write is served, read is dropped. The CPU never does this legally.
- Watchdog: counter increments every cycle in RD_REQ, RD_WAIT or WR_REQ, and clears on entry to IDLE. At TIMEOUT_CYCLES-1:
  - drop the strobes;
  - set bus_error;
  - a read returns ERR_READDATA via RD_DONE; a write goes via WR_DONE.
  - The counter saturates and never wraps.
- Reset mid-transaction: strobes drop on the next edge and the state returns to IDLE. The bus is reset in the same cycle, so no stale readdatavalid is expected; any that arrives is ignored.

Optional Feature:
- Macro: DBRIDGE_READ_HIT_EN.
- Defined:
  - A one-entry read buffer (address, data, valid) loads in RD_DONE.
  - An IDLE read whose address equals the buffered address with valid=1 is served from the buffer with `cpu_stall`=0 and no bus access. This covers a load holding data_read across both CPU states.
  - Any accepted write to the same address updates the buffered data. Timeout or reset invalidates the buffer.
- Undefined: every read goes to the bus, including repeats of the same address.

Test Plan:
- Write, zero waits: write 0xDEADBEEF to 0x00001000 with waitrequest=0 → bus_write high exactly 1 cycle with byteenable=4'hF; stall pattern 1,1,0; bus_error=0.
- Read, two waits: read 0x00001004 with waitrequest=1 for 2 cycles, then readdatavalid 1 cycle later carrying 0x12345678 → cpu_data_readdata=0x12345678 while stall=0; exactly one bus_read acceptance.
- Back-to-back read then write: cpu_data_read in CPU state 0, cpu_data_write in state 1 (sb sequence) → read completes, then the write is issued, with no overlap of bus_read and bus_write.
- Timeout: TIMEOUT_CYCLES=8, read with waitrequest stuck at 1 → strobe drops after 8 cycles; cpu_data_readdata=ERR_READDATA; bus_error=1 and held until reset.
- Reset in RD_WAIT: assert reset → next cycle IDLE, stall=0, bus_read=0; a late readdatavalid does not change cpu_data_readdata.
- Macro on, buffer hit: read 0x2000 twice consecutively → the second read has stall=0 and no bus_read. After a write of 0xA5A5A5A5 to 0x2000, a read returns 0xA5A5A5A5 with no bus access.
